// File: rtl/seg7_bus_display.sv
// seg7_bus_display: bus-mapped 4-digit multiplexed seven-segment controller
// with a prescaled digit scan and per-slot anti-ghost blanking.
module seg7_bus_display #(
    parameter logic [7:0] BASE_ADDR    = 8'hD0,
    parameter int         REFRESH_DIV  = 100000,
    parameter int         BLANK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA_IN,
    input  logic       BUS_WE,
    input  logic       BUS_RE,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_VALID,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] HEX_OUT
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [7:0]    r_dig10, r_dig32, r_mask;
    logic          r_en;
    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [7:0]    r_dout, r_hex;
    logic          r_valid;
    logic [3:0]    r_seg;
    logic [7:0]    w_off, w_rdata;
    logic          w_hit, w_lit;
    logic [15:0]   w_nibs;
    logic [3:0]    w_digit;
    logic [1:0]    w_state;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
        endcase
    endfunction

    // Offset subtraction keeps the window correct even if it sits at the top of the map.
    assign w_off   = BUS_ADDR - BASE_ADDR;
    assign w_hit   = w_off < 8'd4;
    assign w_rdata = w_off[1:0] == 2'd0 ? r_dig10 :
                     w_off[1:0] == 2'd1 ? r_dig32 :
                     w_off[1:0] == 2'd2 ? r_mask  : {7'd0, r_en};
    assign w_nibs  = {r_dig32, r_dig10};
    assign w_digit = w_nibs[{r_idx, 2'b00} +: 4];
    assign w_state = !r_en ? S_OFF : (r_pre < PW'(BLANK_CYCLES)) ? S_BLANK : S_DRIVE;
    assign w_lit   = (w_state == S_DRIVE) && !r_mask[{1'b1, r_idx}];

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_dig10 <= 8'd0;
            r_dig32 <= 8'd0;
            r_mask  <= 8'd0;
            r_en    <= 1'b0;
        end else if (BUS_WE && w_hit) begin
            if (w_off[1:0] == 2'd0) r_dig10 <= BUS_DATA_IN;
            if (w_off[1:0] == 2'd1) r_dig32 <= BUS_DATA_IN;
            if (w_off[1:0] == 2'd2) r_mask  <= BUS_DATA_IN;
            if (w_off[1:0] == 2'd3) r_en    <= BUS_DATA_IN[0];
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN || !r_en) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (r_pre == PW'(REFRESH_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_valid <= 1'b0;
            r_dout  <= 8'd0;
            r_seg   <= 4'hF;
            r_hex   <= 8'hFF;
        end else begin
            r_valid <= BUS_RE && w_hit;
            r_dout  <= (BUS_RE && w_hit) ? w_rdata : 8'd0;
            r_seg   <= w_lit ? ~(4'd1 << r_idx) : 4'hF;
            r_hex   <= w_lit ? {~r_mask[r_idx], seg7(w_digit)} : 8'hFF;
        end
    end

    assign BUS_DATA_VALID = r_valid;
    assign BUS_DATA_OUT   = r_dout;
    assign SEG_SELECT_OUT = r_seg;
    assign HEX_OUT        = r_hex;
endmodule

// File: tb/tb_seg7_bus_display.sv
// tb_seg7_bus_display: directed-vector bench for seg7_bus_display with a short
// refresh period (8-cycle slots, 2 dark cycles per slot).
module tb_seg7_bus_display;
    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] BUS_ADDR = 8'd0;
    logic [7:0] BUS_DATA_IN = 8'd0;
    logic       BUS_WE = 1'b0;
    logic       BUS_RE = 1'b0;
    logic [7:0] BUS_DATA_OUT;
    logic       BUS_DATA_VALID;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] HEX_OUT;
    int checks = 0;
    int errors = 0;

    seg7_bus_display #(.BASE_ADDR(8'hD0), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .CLK(CLK), .RESETN(RESETN), .BUS_ADDR(BUS_ADDR), .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_WE(BUS_WE), .BUS_RE(BUS_RE), .BUS_DATA_OUT(BUS_DATA_OUT),
        .BUS_DATA_VALID(BUS_DATA_VALID), .SEG_SELECT_OUT(SEG_SELECT_OUT), .HEX_OUT(HEX_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic dark(input string tag);
        chk({tag, "_seg"}, {28'd0, SEG_SELECT_OUT}, 32'hF);
        chk({tag, "_hex"}, {24'd0, HEX_OUT}, 32'hFF);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a;
        BUS_DATA_IN = d;
        BUS_WE = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic ev, input logic [7:0] ed);
        BUS_ADDR = a;
        BUS_RE = 1'b1;
        @(negedge CLK);
        BUS_RE = 1'b0;
        chk({tag, "_valid"}, {31'd0, BUS_DATA_VALID}, {31'd0, ev});
        chk({tag, "_data"}, {24'd0, BUS_DATA_OUT}, {24'd0, ed});
    endtask

    // Sample n cycles after an enable write; segs/hexes hold digit3..digit0 expectations.
    task automatic scan(input string tag, input int n, input logic [15:0] segs, input logic [31:0] hexes);
        int pos;
        int d;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            pos = (k - 1) % 8;
            d = ((k - 1) / 8) % 4;
            if (pos < 2) begin
                dark(tag);
            end else begin
                chk({tag, "_seg"}, {28'd0, SEG_SELECT_OUT}, {28'd0, segs[d*4 +: 4]});
                chk({tag, "_hex"}, {24'd0, HEX_OUT}, {24'd0, hexes[d*8 +: 8]});
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        dark("in_reset");
        chk("in_reset_valid", {31'd0, BUS_DATA_VALID}, 32'd0);
        RESETN = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            dark("idle");
            chk("idle_valid", {31'd0, BUS_DATA_VALID}, 32'd0);
            chk("idle_data", {24'd0, BUS_DATA_OUT}, 32'd0);
        end

        wr(8'hD0, 8'h21);
        wr(8'hD1, 8'h43);
        wr(8'hD3, 8'h01);
        scan("scan", 40, 16'h7BDE, 32'h99B0A4F9);

        wr(8'hD3, 8'h00);
        wr(8'hD2, 8'h41);
        wr(8'hD3, 8'h01);
        scan("dpblank", 40, 16'h7FDE, 32'h99FFA479);

        rd("rd_dig32", 8'hD1, 1'b1, 8'h43);
        rd("rd_mask", 8'hD2, 1'b1, 8'h41);
        rd("rd_ctrl", 8'hD3, 1'b1, 8'h01);
        rd("rd_out_hi", 8'hD4, 1'b0, 8'h00);
        rd("rd_out_lo", 8'hCF, 1'b0, 8'h00);
        BUS_ADDR = 8'hD0;
        BUS_DATA_IN = 8'h55;
        BUS_WE = 1'b1;
        BUS_RE = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0;
        BUS_RE = 1'b0;
        chk("rw_old_valid", {31'd0, BUS_DATA_VALID}, 32'd1);
        chk("rw_old_data", {24'd0, BUS_DATA_OUT}, 32'h21);
        @(negedge CLK);
        chk("valid_drop", {31'd0, BUS_DATA_VALID}, 32'd0);
        wr(8'hD4, 8'hAA);
        wr(8'hCF, 8'hAA);
        rd("rd_new", 8'hD0, 1'b1, 8'h55);
        wr(8'hD3, 8'hFE);
        rd("rd_ctrl_ro", 8'hD3, 1'b1, 8'h00);

        wr(8'hD2, 8'h00);
        wr(8'hD3, 8'h01);
        scan("pre_dis", 20, 16'h7BDE, 32'h99B09292);
        wr(8'hD3, 8'h00);
        @(negedge CLK);
        dark("disabled");
        repeat (3) begin
            @(negedge CLK);
            dark("disabled_hold");
        end
        wr(8'hD3, 8'h01);
        scan("reenable", 12, 16'h7BDE, 32'h99B09292);

        #2 RESETN = 1'b0;
        #1 dark("async_rst");
        chk("async_rst_valid", {31'd0, BUS_DATA_VALID}, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        rd("rst_dig10", 8'hD0, 1'b1, 8'h00);
        rd("rst_dig32", 8'hD1, 1'b1, 8'h00);
        rd("rst_mask", 8'hD2, 1'b1, 8'h00);
        rd("rst_ctrl", 8'hD3, 1'b1, 8'h00);
        repeat (12) begin
            @(negedge CLK);
            dark("post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
